// File: rtl/arat_multi.sv
// arat_multi: architectural register alias table for an N-wide commit stage.
// It holds the committed arch->phys map and applies up to COMMIT_W in-order
// commits per cycle. An exception in an older lane cuts off younger lanes.
// Each overwritten phys reg is released to the free list one cycle later.
// An IDLE/HOLD FSM freezes the table as a recovery snapshot after a flush.
//
// Handshake: recover_req is a single-cycle pulse sampled in IDLE. The next
// cycle the FSM is in HOLD and recover_valid=1. The table stays frozen until
// a cycle with recover_ack=1, and recover_valid drops the cycle after that.
// recover_valid is a direct decode of the state register and doubles as the
// FSM state observation point.
//
// Optional feature macro: ARAT_DUP_CHECK_EN enables the sticky err_dup check.
// When the macro is undefined, err_dup is tied to 0.
module arat_multi #(
  parameter int COMMIT_W = 3,
  parameter int AREG_N   = 8,
  parameter int PREG_N   = 32,
  parameter int AREG_W   = $clog2(AREG_N),
  parameter int PREG_W   = $clog2(PREG_N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COMMIT_W-1:0]        commit_valid,
  input  logic [COMMIT_W-1:0]        commit_regwr,
  input  logic [COMMIT_W-1:0]        commit_exp,
  input  logic [COMMIT_W*AREG_W-1:0] commit_rw,
  input  logic [COMMIT_W*PREG_W-1:0] commit_pw,
  output logic [AREG_N*PREG_W-1:0]   arat_p_list,
  output logic [COMMIT_W-1:0]        free_valid,
  output logic [COMMIT_W*PREG_W-1:0] free_preg,
  input  logic                       recover_req,
  output logic                       recover_valid,
  input  logic                       recover_ack,
  output logic                       err_dup
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [PREG_W-1:0]       map_q   [AREG_N];
  logic [PREG_W-1:0]       map_d   [AREG_N];
  logic [AREG_W-1:0]       rw      [COMMIT_W];
  logic [PREG_W-1:0]       pw      [COMMIT_W];
  logic [PREG_W-1:0]       prev    [COMMIT_W];
  logic [PREG_W-1:0]       free_q  [COMMIT_W];
  logic [COMMIT_W-1:0]     free_v_q;
  logic [COMMIT_W:0]       kill_chain;
  logic [COMMIT_W-1:0]     eff;

  // Unpack the per-lane destination fields.
  always_comb begin
    for (int i = 0; i < COMMIT_W; i++) begin
      rw[i] = commit_rw[i*AREG_W +: AREG_W];
      pw[i] = commit_pw[i*PREG_W +: PREG_W];
    end
  end

  // Lane effectiveness: any older excepting lane kills younger lanes. A lane
  // with regwr=0 never blocks younger lanes. Nothing commits in HOLD.
  always_comb begin
    kill_chain    = '0;
    eff           = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      eff[i] = commit_valid[i] & commit_regwr[i] & ~commit_exp[i] &
               ~kill_chain[i] & (state_q == IDLE);
      kill_chain[i+1] = kill_chain[i] | (commit_valid[i] & commit_exp[i]);
    end
  end

  // The mapping each lane overwrites is the youngest older same-reg write, or
  // the table entry when no older lane wrote it. This makes intra-cycle chains
  // release the intermediate phys reg.
  always_comb begin
    for (int i = 0; i < COMMIT_W; i++) begin
      prev[i] = map_q[rw[i]];
      for (int j = 0; j < i; j++) begin
        if (eff[j] && (rw[j] == rw[i])) prev[i] = pw[j];
      end
    end
  end

  // Next table: the youngest effective lane that targets an entry wins.
  always_comb begin
    for (int a = 0; a < AREG_N; a++) begin
      map_d[a] = map_q[a];
      for (int i = 0; i < COMMIT_W; i++) begin
        if (eff[i] && (rw[i] == AREG_W'(a))) map_d[a] = pw[i];
      end
    end
  end

  // FSM next state: a flush request enters HOLD, and an ack releases it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (recover_req) state_d = HOLD;
      HOLD:    if (recover_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Committed mapping table. Reset loads the identity map.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < AREG_N; a++) map_q[a] <= PREG_W'(a);
    end else begin
      for (int a = 0; a < AREG_N; a++) map_q[a] <= map_d[a];
    end
  end

  // Registered free-list release. Non-effective lanes output zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      free_v_q <= '0;
      for (int i = 0; i < COMMIT_W; i++) free_q[i] <= '0;
    end else begin
      free_v_q <= eff;
      for (int i = 0; i < COMMIT_W; i++) free_q[i] <= eff[i] ? prev[i] : '0;
    end
  end

  assign recover_valid = (state_q == HOLD);
  assign free_valid    = free_v_q;

  for (genvar a = 0; a < AREG_N; a++) begin : g_list
    assign arat_p_list[a*PREG_W +: PREG_W] = map_q[a];
  end

  for (genvar i = 0; i < COMMIT_W; i++) begin : g_free
    assign free_preg[i*PREG_W +: PREG_W] = free_q[i];
  end

`ifdef ARAT_DUP_CHECK_EN
  logic [AREG_N-1:0] wr_hit;
  logic              dup_d;
  logic              err_q;

  // Duplicate detection: an effective pw already lives in an entry that
  // survives this cycle, or two effective lanes carry the same pw.
  always_comb begin
    wr_hit = '0;
    dup_d  = 1'b0;
    for (int a = 0; a < AREG_N; a++) begin
      for (int i = 0; i < COMMIT_W; i++) begin
        if (eff[i] && (rw[i] == AREG_W'(a))) wr_hit[a] = 1'b1;
      end
    end
    for (int i = 0; i < COMMIT_W; i++) begin
      if (eff[i]) begin
        for (int a = 0; a < AREG_N; a++) begin
          if (!wr_hit[a] && (map_q[a] == pw[i])) dup_d = 1'b1;
        end
        for (int j = 0; j < COMMIT_W; j++) begin
          if ((j != i) && eff[j] && (pw[j] == pw[i])) dup_d = 1'b1;
        end
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_q | dup_d;
  end

  assign err_dup = err_q;
`else
  assign err_dup = 1'b0;
`endif

endmodule

// File: tb/tb_arat_multi.sv
// tb_arat_multi: directed bench for arat_multi (COMMIT_W=3, AREG_N=8, PREG_N=32).
// The driver pushes the expected free-list response of every driven cycle
// into exp_q. A monitor pops and compares on the falling edge after the
// capturing edge. Table, recovery and error outputs are checked inline
// against hand-computed constants.
module tb_arat_multi;

  localparam int CW = 3;
  localparam int AN = 8;
  localparam int PN = 32;
  localparam int AW = 3;
  localparam int PW = 5;
  localparam int RESP_W = CW + CW*PW;

`ifdef ARAT_DUP_CHECK_EN
  localparam logic DUP_EXP = 1'b1;
`else
  localparam logic DUP_EXP = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [CW-1:0]     commit_valid;
  logic [CW-1:0]     commit_regwr;
  logic [CW-1:0]     commit_exp;
  logic [CW*AW-1:0]  commit_rw;
  logic [CW*PW-1:0]  commit_pw;
  logic [AN*PW-1:0]  arat_p_list;
  logic [CW-1:0]     free_valid;
  logic [CW*PW-1:0]  free_preg;
  logic              recover_req;
  logic              recover_valid;
  logic              recover_ack;
  logic              err_dup;

  logic [RESP_W-1:0] exp_q[$];
  int                n_chk;
  int                n_err;

  arat_multi #(.COMMIT_W(CW), .AREG_N(AN), .PREG_N(PN)) dut (
    .clk          (clk),
    .rst          (rst),
    .commit_valid (commit_valid),
    .commit_regwr (commit_regwr),
    .commit_exp   (commit_exp),
    .commit_rw    (commit_rw),
    .commit_pw    (commit_pw),
    .arat_p_list  (arat_p_list),
    .free_valid   (free_valid),
    .free_preg    (free_preg),
    .recover_req  (recover_req),
    .recover_valid(recover_valid),
    .recover_ack  (recover_ack),
    .err_dup      (err_dup)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [PW-1:0] ent(input int a);
    return arat_p_list[a*PW +: PW];
  endfunction

  function automatic logic [CW*AW-1:0] r3(input logic [AW-1:0] l0, l1, l2);
    return {l2, l1, l0};
  endfunction

  function automatic logic [CW*PW-1:0] p3(input logic [PW-1:0] l0, l1, l2);
    return {l2, l1, l0};
  endfunction

  function automatic logic [RESP_W-1:0] resp(input logic [CW-1:0] fv,
                                             input logic [PW-1:0] f0, f1, f2);
    return {fv, f2, f1, f0};
  endfunction

  // Driver: apply one cycle of inputs and queue the expected release.
  task automatic cyc(input logic [CW-1:0] v, wr, ex, input logic [CW*AW-1:0] rw,
                     input logic [CW*PW-1:0] pw, input logic req, ack,
                     input logic [RESP_W-1:0] exp_resp);
    commit_valid = v;
    commit_regwr = wr;
    commit_exp   = ex;
    commit_rw    = rw;
    commit_pw    = pw;
    recover_req  = req;
    recover_ack  = ack;
    @(posedge clk);
    exp_q.push_back(exp_resp);
    #1;
    commit_valid = '0;
    commit_regwr = '0;
    commit_exp   = '0;
    recover_req  = 1'b0;
    recover_ack  = 1'b0;
  endtask

  task automatic idle();
    cyc('0, '0, '0, '0, '0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: compare the released registers against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (exp_q.size() > 0) begin
          logic [RESP_W-1:0] e;
          e = exp_q.pop_front();
          chk("free_resp", 32'({free_valid, free_preg}), 32'(e));
        end else if (free_valid != '0) begin
          chk("free_unexpected", 32'(free_valid), 32'd0);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    commit_valid = '0; commit_regwr = '0; commit_exp = '0;
    commit_rw = '0; commit_pw = '0; recover_req = 1'b0; recover_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < AN; a++) chk("reset_entry", 32'(ent(a)), 32'(a));
    chk("reset_free_valid", 32'(free_valid), 32'd0);
    chk("reset_recover_valid", 32'(recover_valid), 32'd0);
    chk("reset_err_dup", 32'(err_dup), 32'd0);
    rst = 1'b1;

    // Three lanes, two writing r3: the youngest wins and the chain frees p10.
    cyc(3'b111, 3'b111, 3'b000, r3(3, 5, 3), p3(10, 11, 12), 0, 0, resp(3'b111, 3, 5, 10));
    chk("t2_entry3", 32'(ent(3)), 32'd12);
    chk("t2_entry5", 32'(ent(5)), 32'd11);

    // Lane1 excepts: lane0 applies, lane1 and lane2 are discarded.
    cyc(3'b111, 3'b111, 3'b010, r3(1, 7, 2), p3(9, 20, 13), 0, 0, resp(3'b001, 1, 0, 0));
    chk("t3_entry1", 32'(ent(1)), 32'd9);
    chk("t3_entry2", 32'(ent(2)), 32'd2);
    chk("t3_entry7", 32'(ent(7)), 32'd7);

    // Lane0 regwr=0 does not block lane1.
    cyc(3'b011, 3'b010, 3'b000, r3(4, 4, 0), p3(21, 14, 0), 0, 0, resp(3'b010, 0, 4, 0));
    chk("t4_entry4", 32'(ent(4)), 32'd14);

    // Exception on lane0 kills every younger lane.
    cyc(3'b111, 3'b111, 3'b001, r3(5, 3, 2), p3(22, 23, 24), 0, 0, resp(3'b000, 0, 0, 0));
    chk("kill_entry5", 32'(ent(5)), 32'd11);
    chk("kill_entry3", 32'(ent(3)), 32'd12);

    // A flush with a same-cycle commit: the commit applies, then HOLD.
    cyc(3'b001, 3'b001, 3'b000, r3(6, 0, 0), p3(15, 0, 0), 1, 0, resp(3'b001, 6, 0, 0));
    chk("t5_entry6", 32'(ent(6)), 32'd15);
    chk("t5_recover_valid", 32'(recover_valid), 32'd1);
    cyc(3'b001, 3'b001, 3'b000, r3(6, 0, 0), p3(16, 0, 0), 1, 0, resp(3'b000, 0, 0, 0));
    chk("hold_entry6", 32'(ent(6)), 32'd15);
    chk("hold_recover_valid", 32'(recover_valid), 32'd1);
    cyc('0, '0, '0, '0, '0, 0, 1, resp(3'b000, 0, 0, 0));
    chk("ack_recover_valid", 32'(recover_valid), 32'd0);
    // An ack in IDLE is ignored, and commits resume.
    cyc(3'b100, 3'b100, 3'b000, r3(0, 0, 6), p3(0, 0, 17), 0, 1, resp(3'b100, 0, 0, 15));
    chk("resume_entry6", 32'(ent(6)), 32'd17);
    chk("idle_ack_recover_valid", 32'(recover_valid), 32'd0);

    // Duplicate mapping: p7 is still held by entry7.
    chk("pre_dup_err", 32'(err_dup), 32'd0);
    cyc(3'b001, 3'b001, 3'b000, r3(0, 0, 0), p3(7, 0, 0), 0, 0, resp(3'b001, 0, 0, 0));
    chk("dup_entry0", 32'(ent(0)), 32'd7);
    chk("dup_err_set", 32'(err_dup), 32'(DUP_EXP));
    repeat (10) idle();
    chk("dup_err_sticky", 32'(err_dup), 32'(DUP_EXP));

    // A three-deep chain on r0 releases 7, 18, 19 and leaves p20.
    cyc(3'b111, 3'b111, 3'b000, r3(0, 0, 0), p3(18, 19, 20), 0, 0, resp(3'b111, 7, 18, 19));
    chk("chain_entry0", 32'(ent(0)), 32'd20);

    // Async reset in the middle of HOLD restores identity with no ack.
    cyc('0, '0, '0, '0, '0, 1, 0, resp(3'b000, 0, 0, 0));
    chk("hold2_recover_valid", 32'(recover_valid), 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("arst_recover_valid", 32'(recover_valid), 32'd0);
    chk("arst_entry0", 32'(ent(0)), 32'd0);
    chk("arst_entry6", 32'(ent(6)), 32'd6);
    chk("arst_err_dup", 32'(err_dup), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(3'b001, 3'b001, 3'b000, r3(6, 0, 0), p3(25, 0, 0), 0, 0, resp(3'b001, 6, 0, 0));
    chk("post_rst_entry6", 32'(ent(6)), 32'd25);
    chk("post_rst_recover_valid", 32'(recover_valid), 32'd0);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
